param_vending_machine: RTL and testbench
========================================

// Module: param_vending_machine
// PURPOSE
//   Parametrised credit-accumulating vending controller; successor to the fixed 4-state coin FSM.
//   - Coin values, price and credit width are parameters; state set is fixed.
//   - Adds cancel/refund, a serial change dispenser (one pulse per unit), coin rejection while busy,
//     and an optional inactivity timeout.
//   - Sits between the coin acceptor front-end and the dispenser/change-hopper drivers.
// PARAMETERS
//   PRICE       4    product price in credit units; >=1
//   COINA_VAL   1    units credited for coin code 2'b01; >=1
//   COINB_VAL   2    units credited for coin code 2'b10; >=1
//   CREDIT_W    4    credit register width; PRICE+max(COINA_VAL,COINB_VAL)-1 <= 2**CREDIT_W-1
//   TIMEOUT_CYC 1000 idle cycles in ACCUM before auto-refund (VM_TIMEOUT_EN only); >=2
//   TO_W        10   timeout counter width; 2**TO_W > TIMEOUT_CYC
// PORTS
//   clk          in   1         single clock, all logic on rising edge
//   reset        in   1         synchronous, active-high
//   in           in   2         coin code, sampled every cycle: 01=coin A, 10=coin B, 00/11=no coin
//   cancel       in   1         refund request, level sampled each cycle
//   vend         out  1         one-cycle dispense pulse
//   change_pulse out  1         one pulse per credit unit returned, consecutive cycles
//   coin_reject  out  1         one-cycle pulse: coin present while it cannot be accepted
//   credit       out  CREDIT_W  current credit in units
//   busy         out  1         1 while state is VEND or CHANGE
// BEHAVIOUR
//   - All outputs registered. On reset: state=IDLE, credit=0, vend=change_pulse=coin_reject=busy=0.
//   - Reset mid-operation abandons remaining change; no further pulses.
//   - States: IDLE (credit==0), ACCUM (0<credit<PRICE), VEND, CHANGE.
//   - IDLE/ACCUM, coin valid, cancel=0: credit<=credit+val.
//       sum>=PRICE -> VEND; else -> ACCUM.
//   - VEND: vend<=1 for exactly one cycle; credit<=credit-PRICE.
//       -> CHANGE if remainder>0, else IDLE.
//   - Latency: coin completing price sampled in cycle k -> state VEND in k+1 -> vend=1 in k+2.
//       First change_pulse (if any) in k+3.
//   - CHANGE: each cycle change_pulse<=1 and credit<=credit-1; leave to IDLE when credit reaches 0.
//       A remainder of N yields exactly N back-to-back pulses.
//   - cancel in ACCUM -> CHANGE: full credit refunded, no vend.
//       cancel in IDLE, VEND or CHANGE is ignored.
//   - cancel and coin in the same ACCUM/IDLE cycle: cancel wins.
//       Coin not credited; coin_reject<=1 for one cycle.
//   - Coin valid in VEND or CHANGE: coin_reject<=1 for one cycle; credit and state unaffected.
//   - Parameter constraint guarantees credit never overflows; no saturation logic.
//   - in==2'b11: treated as no coin, no reject.
// CONFIGURATION
//   VM_TIMEOUT_EN defined:
//     - TO_W-bit idle counter runs in ACCUM; cleared on accepted coin and on leaving ACCUM.
//     - Counter reaching TIMEOUT_CYC-1 with no coin that cycle -> CHANGE (same as cancel).
//       The coin wins if it arrives that cycle.
//   VM_TIMEOUT_EN undefined:
//     - No counter; credit held in ACCUM indefinitely; TIMEOUT_CYC/TO_W unused.
// TESTING (defaults unless stated)
//   1. in=01 x4 consecutive cycles
//      -> vend=1 one cycle, 2 cycles after 4th coin; no change_pulse; credit=0; IDLE.
//   2. in=10,01,10 (credit 5)
//      -> one vend pulse, then exactly one change_pulse; credit=0.
//   3. in=01,01 then cancel=1
//      -> 2 consecutive change_pulse; vend never asserted; credit 2->1->0.
//   4. Coin during busy and simultaneous cancel:
//      - in=10 while busy=1 -> coin_reject one cycle, credit unchanged.
//      - in=01 with cancel=1 at credit 1 -> coin_reject, 1 change_pulse.
//   5. Reset mid-refund: credit 3, cancel, reset after first change_pulse
//      -> no further pulses; all outputs 0; credit=0.
//   6. Timeout, TIMEOUT_CYC=8:
//      - With VM_TIMEOUT_EN: in=01 then idle -> 1 change_pulse after 8 idle cycles.
//      - Without it: credit still 1 after 100 cycles.

Source files
------------

// File: rtl/param_vending_machine.sv
// ============================================================================
// Module   : param_vending_machine
// Purpose  : Credit-accumulating vending controller with refund, serial change
//            and coin rejection; optional inactivity timeout via VM_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module param_vending_machine #(
  parameter int PRICE       = 4,
  parameter int COINA_VAL   = 1,
  parameter int COINB_VAL   = 2,
  parameter int CREDIT_W    = 4,
  parameter int TIMEOUT_CYC = 1000,
  parameter int TO_W        = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          in,
  input  logic                cancel,
  output logic                vend,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam logic [CREDIT_W-1:0] C_PRICE = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] C_COINA = CREDIT_W'(COINA_VAL);
  localparam logic [CREDIT_W-1:0] C_COINB = CREDIT_W'(COINB_VAL);
  localparam logic [CREDIT_W-1:0] C_ONE   = CREDIT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_VEND   = 2'd2,
    S_CHANGE = 2'd3
  } state_t;

  state_t              state;
  logic                coin_valid;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] sum;
  logic                timeout_hit;

  always_comb begin
    coin_valid = (in == 2'b01) || (in == 2'b10);
    coin_val   = (in == 2'b10) ? C_COINB : C_COINA;
    sum        = credit + coin_val;
  end

`ifdef VM_TIMEOUT_EN
  logic [TO_W-1:0] idle_cnt;

  assign timeout_hit = (idle_cnt == TO_W'(TIMEOUT_CYC - 1));

  // Counts only while idling in ACCUM; any coin, cancel or exit restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if ((state == S_ACCUM) && !coin_valid && !cancel && !timeout_hit) begin
      idle_cnt <= idle_cnt + TO_W'(1);
    end else begin
      idle_cnt <= '0;
    end
  end
`else
  // Constant false; the timeout parameters stay part of the interface.
  assign timeout_hit = (TIMEOUT_CYC < 0) && (TO_W < 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      credit       <= '0;
      vend         <= 1'b0;
      change_pulse <= 1'b0;
      coin_reject  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      vend         <= 1'b0;
      change_pulse <= 1'b0;
      coin_reject  <= 1'b0;
      case (state)
        S_IDLE, S_ACCUM: begin
          if (cancel) begin
            coin_reject <= coin_valid;
            if (state == S_ACCUM) begin
              state <= S_CHANGE;
              busy  <= 1'b1;
            end
          end else if (coin_valid) begin
            credit <= sum;
            if (sum >= C_PRICE) begin
              state <= S_VEND;
              busy  <= 1'b1;
            end else begin
              state <= S_ACCUM;
            end
          end else if (timeout_hit && (state == S_ACCUM)) begin
            state <= S_CHANGE;
            busy  <= 1'b1;
          end
        end
        S_VEND: begin
          vend        <= 1'b1;
          coin_reject <= coin_valid;
          credit      <= credit - C_PRICE;
          if (credit != C_PRICE) begin
            state <= S_CHANGE;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_CHANGE: begin
          change_pulse <= 1'b1;
          coin_reject  <= coin_valid;
          credit       <= credit - C_ONE;
          if (credit == C_ONE) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_param_vending_machine.sv
// ============================================================================
// Module   : tb_param_vending_machine
// Purpose  : Directed self-checking bench for param_vending_machine.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_param_vending_machine;

  logic       clk;
  logic       reset;
  logic [1:0] coin_in;
  logic       cancel;
  logic       vend;
  logic       change_pulse;
  logic       coin_reject;
  logic [3:0] credit;
  logic       busy;

  int checks = 0;
  int passes = 0;

  param_vending_machine #(
    .PRICE(4), .COINA_VAL(1), .COINB_VAL(2), .CREDIT_W(4),
    .TIMEOUT_CYC(8), .TO_W(4)
  ) dut (
    .clk(clk), .reset(reset), .in(coin_in), .cancel(cancel),
    .vend(vend), .change_pulse(change_pulse), .coin_reject(coin_reject),
    .credit(credit), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs, let one rising edge sample them, then settle past the edge.
  task automatic tick(input logic [1:0] c, input logic k);
    coin_in = c;
    cancel  = k;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_out(input string tag, input logic v, input logic cp,
                           input logic cr, input logic [3:0] cred, input logic b);
    check({tag, ".vend"},   32'(vend),         32'(v));
    check({tag, ".change"}, 32'(change_pulse), 32'(cp));
    check({tag, ".reject"}, 32'(coin_reject),  32'(cr));
    check({tag, ".credit"}, 32'(credit),       32'(cred));
    check({tag, ".busy"},   32'(busy),         32'(b));
  endtask

  initial begin
    int pulses;
    reset = 1'b1; coin_in = 2'b00; cancel = 1'b0;
    tick(2'b00, 1'b0);
    tick(2'b00, 1'b0);
    check_out("reset", 0, 0, 0, 4'd0, 0);
    reset = 1'b0;

    // Four A coins: vend two edges after the fourth coin, no change.
    tick(2'b01, 1'b0); check_out("t1_c1", 0, 0, 0, 4'd1, 0);
    tick(2'b01, 1'b0); check_out("t1_c2", 0, 0, 0, 4'd2, 0);
    tick(2'b01, 1'b0); check_out("t1_c3", 0, 0, 0, 4'd3, 0);
    tick(2'b01, 1'b0); check_out("t1_c4", 0, 0, 0, 4'd4, 1);
    tick(2'b00, 1'b0); check_out("t1_vend", 1, 0, 0, 4'd0, 0);
    tick(2'b00, 1'b0); check_out("t1_after", 0, 0, 0, 4'd0, 0);

    // B,A,B = 5: vend then exactly one change pulse.
    tick(2'b10, 1'b0); check_out("t2_c1", 0, 0, 0, 4'd2, 0);
    tick(2'b01, 1'b0); check_out("t2_c2", 0, 0, 0, 4'd3, 0);
    tick(2'b10, 1'b0); check_out("t2_c3", 0, 0, 0, 4'd5, 1);
    tick(2'b00, 1'b0); check_out("t2_vend", 1, 0, 0, 4'd1, 1);
    tick(2'b00, 1'b0); check_out("t2_chg", 0, 1, 0, 4'd0, 0);
    tick(2'b00, 1'b0); check_out("t2_after", 0, 0, 0, 4'd0, 0);

    // Cancel at credit 2: two back-to-back refund pulses, no vend.
    tick(2'b01, 1'b0); check_out("t3_c1", 0, 0, 0, 4'd1, 0);
    tick(2'b01, 1'b0); check_out("t3_c2", 0, 0, 0, 4'd2, 0);
    tick(2'b00, 1'b1); check_out("t3_cancel", 0, 0, 0, 4'd2, 1);
    tick(2'b00, 1'b0); check_out("t3_chg1", 0, 1, 0, 4'd1, 1);
    tick(2'b00, 1'b0); check_out("t3_chg2", 0, 1, 0, 4'd0, 0);
    tick(2'b00, 1'b0); check_out("t3_after", 0, 0, 0, 4'd0, 0);

    // Cancel in IDLE is ignored; code 11 is not a coin.
    tick(2'b00, 1'b1); check_out("idle_cancel", 0, 0, 0, 4'd0, 0);
    tick(2'b11, 1'b0); check_out("code11", 0, 0, 0, 4'd0, 0);

    // Coin arriving while in VEND is rejected and never credited.
    tick(2'b10, 1'b0); check_out("t4a_c1", 0, 0, 0, 4'd2, 0);
    tick(2'b10, 1'b0); check_out("t4a_c2", 0, 0, 0, 4'd4, 1);
    tick(2'b10, 1'b0); check_out("t4a_busy", 1, 0, 1, 4'd0, 0);
    tick(2'b00, 1'b0); check_out("t4a_after", 0, 0, 0, 4'd0, 0);

    // Coin with cancel at credit 1: cancel wins, coin rejected, one pulse.
    tick(2'b01, 1'b0); check_out("t4b_c1", 0, 0, 0, 4'd1, 0);
    tick(2'b01, 1'b1); check_out("t4b_both", 0, 0, 1, 4'd1, 1);
    tick(2'b00, 1'b0); check_out("t4b_chg", 0, 1, 0, 4'd0, 0);
    tick(2'b00, 1'b0); check_out("t4b_after", 0, 0, 0, 4'd0, 0);

    // Reset after the first refund pulse abandons the remaining change.
    tick(2'b01, 1'b0); check_out("t5_c1", 0, 0, 0, 4'd1, 0);
    tick(2'b10, 1'b0); check_out("t5_c2", 0, 0, 0, 4'd3, 0);
    tick(2'b00, 1'b1); check_out("t5_cancel", 0, 0, 0, 4'd3, 1);
    tick(2'b00, 1'b0); check_out("t5_chg1", 0, 1, 0, 4'd2, 1);
    reset = 1'b1;
    tick(2'b00, 1'b0); check_out("t5_reset", 0, 0, 0, 4'd0, 0);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick(2'b00, 1'b0);
      if (change_pulse === 1'b1) pulses++;
    end
    check("t5_no_more_pulses", 32'(pulses), 32'd0);
    check_out("t5_after", 0, 0, 0, 4'd0, 0);

    // Inactivity behaviour with TIMEOUT_CYC = 8.
    tick(2'b01, 1'b0); check_out("t6_c1", 0, 0, 0, 4'd1, 0);
`ifdef VM_TIMEOUT_EN
    for (int i = 0; i < 7; i++) tick(2'b00, 1'b0);
    check_out("t6_idle7", 0, 0, 0, 4'd1, 0);
    tick(2'b00, 1'b0); check_out("t6_idle8", 0, 0, 0, 4'd1, 1);
    tick(2'b00, 1'b0); check_out("t6_refund", 0, 1, 0, 4'd0, 0);
    tick(2'b00, 1'b0); check_out("t6_after", 0, 0, 0, 4'd0, 0);
`else
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      tick(2'b00, 1'b0);
      if (change_pulse === 1'b1 || busy === 1'b1) pulses++;
    end
    check("t6_no_timeout_activity", 32'(pulses), 32'd0);
    check_out("t6_held", 0, 0, 0, 4'd1, 0);
    tick(2'b00, 1'b1); check_out("t6_cancel", 0, 0, 0, 4'd1, 1);
    tick(2'b00, 1'b0); check_out("t6_refund", 0, 1, 0, 4'd0, 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
